// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message padder.
// Widths are fixed by RFC 1321: 64-byte blocks with the length in the last 8 bytes.
package md5_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    EMIT   = 2'd2,
    LENBLK = 2'd3
  } state_t;

  typedef logic [31:0] word_t;
  typedef word_t [0:15] block_t;

  localparam int         BLK_BYTES = 64;
  localparam int         LEN_POS   = 56;
  localparam logic [7:0] PAD_BYTE  = 8'h80;

endpackage

// File: rtl/md5_blk_buf.sv
// 64-byte block register: byte write at idx, clear, pad-fill from idx, and length insert.
// Byte k lives at bits [8k+7:8k], so word w naturally carries byte 4w in its low byte.
module md5_blk_buf
  import md5_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic        i_pad,
  input  logic        i_len,
  input  logic [5:0]  i_idx,
  input  logic [7:0]  i_byte,
  input  logic [63:0] i_len_bits,
  output word_t       o_m [0:15]
);

  logic [8*BLK_BYTES-1:0] r_flat;
  logic [8*BLK_BYTES-1:0] w_nxt;
  logic                   w_upd;

  assign w_upd = i_clr | i_wr | i_pad | i_len;

  // Later operations overlay earlier ones, so clear + length builds a length-only block.
  always_comb begin
    w_nxt = i_clr ? '0 : r_flat;
    for (int k = 0; k < BLK_BYTES; k++) begin
      if (i_wr && (i_idx == 6'(k)))
        w_nxt[8*k +: 8] = i_byte;
      if (i_pad && (i_idx == 6'(k)))
        w_nxt[8*k +: 8] = PAD_BYTE;
      else if (i_pad && (6'(k) > i_idx))
        w_nxt[8*k +: 8] = 8'h00;
      if (i_len && (k >= LEN_POS))
        w_nxt[8*k +: 8] = i_len_bits[8*(k-LEN_POS) +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_flat <= '0;
    else if (w_upd)
      r_flat <= w_nxt;
  end

  always_comb begin
    for (int w = 0; w < 16; w++)
      o_m[w] = r_flat[32*w +: 32];
  end

endmodule

// File: rtl/md5_pad.sv
// MD5 message padder: accepts a byte stream, applies RFC 1321 padding and
// hands 512-bit blocks to the hash core over a valid/ready handshake.
module md5_pad
  import md5_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        end_i,
  output logic        byte_ready_o,
  output logic [31:0] M_o [0:15],
  output logic        blk_valid_o,
  input  logic        blk_ready_i,
  output logic        blk_last_o
);

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [60:0] r_cnt;
  logic        r_last;
  logic        r_valid;
  logic        r_pend_end;
  logic        r_len_pend;

  logic        w_fill;
  logic        w_xfer;
  logic        w_hs;
  logic        w_wr;
  logic        w_pad;
  logic        w_len_ins;
  logic        w_clr;
  logic        w_len_fits;
  logic [63:0] w_len_bits;

  assign w_fill     = (r_state == FILL);
  assign w_xfer     = (byte_valid_i | end_i) & w_fill;
  assign w_hs       = r_valid & blk_ready_i;
  assign w_len_fits = (r_idx < 6'(LEN_POS));
  assign w_len_bits = {r_cnt, 3'b000};

  assign w_wr      = w_fill & byte_valid_i;
  assign w_pad     = (r_state == PAD);
  assign w_len_ins = (w_pad & w_len_fits) | (r_state == LENBLK);
  // Every handshake empties the buffer; LENBLK re-clears so it never depends on that.
  assign w_clr     = ((r_state == EMIT) & w_hs) | (r_state == LENBLK);

  assign byte_ready_o = w_fill;
  assign blk_valid_o  = r_valid;
  assign blk_last_o   = r_last;

  md5_blk_buf u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clr      (w_clr),
    .i_wr       (w_wr),
    .i_pad      (w_pad),
    .i_len      (w_len_ins),
    .i_idx      (r_idx),
    .i_byte     (byte_i),
    .i_len_bits (w_len_bits),
    .o_m        (M_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= FILL;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_pend_end <= 1'b0;
      r_len_pend <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_xfer) begin
            if (byte_valid_i) begin
              r_idx <= r_idx + 6'd1;
              r_cnt <= r_cnt + 61'd1;
            end
            // A full block must go out before an accompanying end can be padded.
            if (byte_valid_i && (r_idx == 6'(BLK_BYTES-1))) begin
              r_state    <= EMIT;
              r_valid    <= 1'b1;
              r_last     <= 1'b0;
              r_pend_end <= end_i;
            end else if (end_i) begin
              r_state <= PAD;
            end
          end
        end
        PAD: begin
          r_state <= EMIT;
          r_valid <= 1'b1;
          if (w_len_fits) begin
            r_last <= 1'b1;
          end else begin
            r_last     <= 1'b0;
            r_len_pend <= 1'b1;
          end
        end
        EMIT: begin
          if (blk_ready_i) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_state    <= FILL;
              r_idx      <= '0;
              r_cnt      <= '0;
              r_last     <= 1'b0;
              r_pend_end <= 1'b0;
              r_len_pend <= 1'b0;
            end else if (r_pend_end) begin
              r_state    <= PAD;
              r_idx      <= '0;
              r_pend_end <= 1'b0;
            end else if (r_len_pend) begin
              r_state    <= LENBLK;
              r_len_pend <= 1'b0;
            end else begin
              r_state <= FILL;
              r_idx   <= '0;
            end
          end
        end
        LENBLK: begin
          r_state <= EMIT;
          r_valid <= 1'b1;
          r_last  <= 1'b1;
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_pad.sv
// Bench for md5_pad: directed vector table, random messages against an RFC 1321
// padding model, backpressure stability, and asynchronous reset sequences.
module tb_md5_pad;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          kind;      // 0: len copies of fill, 1: "abc"
    int          len;
    logic [7:0]  fill;
    bit          end_sep;   // end_i sent alone after the last byte
    int          bp;        // cycles blk_ready_i is held low per block
    int          blk;
    int          word;
    logic [31:0] exp_w;
    logic        exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        end_i;
  logic        byte_ready_o;
  logic [31:0] M_o [0:15];
  logic        blk_valid_o;
  logic        blk_ready_i;
  logic        blk_last_o;

  int          checks   = 0;
  int          failures = 0;
  bit          rand_gap = 1'b0;
  logic [31:0] got_w [0:3][0:15];
  logic        got_last [0:3];
  int          got_n;
  vec_t        vt [10];

  md5_pad dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .end_i        (end_i),
    .byte_ready_o (byte_ready_o),
    .M_o          (M_o),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_last_o   (blk_last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  // Offers one transfer from just after a rising edge and holds it until accepted.
  task automatic xfer(input logic [7:0] b, input logic v, input logic e);
    int guard = 0;
    if (rand_gap && ($urandom_range(0, 3) == 0)) begin
      byte_valid_i = 1'b0;
      end_i        = 1'b0;
      @(posedge clk); #1;
    end
    byte_i       = b;
    byte_valid_i = v;
    end_i        = e;
    while (!byte_ready_o && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!byte_ready_o) chk("xfer_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    end_i        = 1'b0;
  endtask

  task automatic run_msg(input bq_t msg, input bit end_sep, input int bp);
    logic [7:0]  pad[$];
    logic [63:0] bits;
    int          nblk;
    pad = msg;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) pad.push_back(bits[8*i +: 8]);
    nblk  = pad.size() / 64;
    got_n = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < msg.size(); i++)
          xfer(msg[i], 1'b1, (!end_sep && (i == msg.size() - 1)));
        if (end_sep || (msg.size() == 0)) xfer(8'h00, 1'b0, 1'b1);
      end
      begin
        for (int b = 0; b < nblk; b++) begin
          int          g = 0;
          logic [31:0] cap [0:15];
          logic        cap_last;
          bit          stable = 1'b1;
          logic [31:0] ew;
          @(negedge clk);
          while (!blk_valid_o && g < 3000) begin
            @(negedge clk);
            g++;
          end
          if (!blk_valid_o) begin
            chk("blk_timeout", 64'd0, 64'd1);
            break;
          end
          for (int w = 0; w < 16; w++) cap[w] = M_o[w];
          cap_last = blk_last_o;
          for (int w = 0; w < 16; w++) begin
            ew = {pad[b*64+4*w+3], pad[b*64+4*w+2], pad[b*64+4*w+1], pad[b*64+4*w]};
            chk($sformatf("blk%0d_w%0d", b, w), 64'(cap[w]), 64'(ew));
          end
          chk($sformatf("blk%0d_last", b), 64'(cap_last), 64'(b == nblk - 1));
          if (bp > 0) begin
            for (int c = 0; c < bp; c++) begin
              @(negedge clk);
              if (!blk_valid_o || byte_ready_o || (blk_last_o !== cap_last)) stable = 1'b0;
              for (int w = 0; w < 16; w++) if (M_o[w] !== cap[w]) stable = 1'b0;
            end
            chk($sformatf("blk%0d_hold", b), 64'(stable), 64'd1);
          end
          if (b < 4) begin
            for (int w = 0; w < 16; w++) got_w[b][w] = cap[w];
            got_last[b] = cap_last;
          end
          got_n++;
          blk_ready_i = 1'b1;
          @(posedge clk); #1;
          blk_ready_i = 1'b0;
        end
        chk("ready_after_final", 64'(byte_ready_o), 64'd1);
        chk("valid_after_final", 64'(blk_valid_o), 64'd0);
      end
    join
    chk("block_count", 64'(got_n), 64'(nblk));
  endtask

  initial begin
    bq_t         m;
    logic [31:0] acc;

    vt[0] = '{0,  0, 8'h00, 1'b1,  0, 0,  0, 32'h00000080, 1'b1};
    vt[1] = '{0,  0, 8'h00, 1'b1,  0, 0,  7, 32'h00000000, 1'b1};
    vt[2] = '{1,  3, 8'h00, 1'b0,  0, 0,  0, 32'h80636261, 1'b1};
    vt[3] = '{1,  3, 8'h00, 1'b0,  0, 0, 14, 32'h00000018, 1'b1};
    vt[4] = '{0, 55, 8'h61, 1'b0,  0, 0, 13, 32'h80616161, 1'b1};
    vt[5] = '{0, 55, 8'h61, 1'b0,  0, 0, 14, 32'h000001B8, 1'b1};
    vt[6] = '{0, 56, 8'h61, 1'b0,  0, 0, 14, 32'h00000080, 1'b0};
    vt[7] = '{0, 56, 8'h61, 1'b0,  0, 1, 14, 32'h000001C0, 1'b1};
    vt[8] = '{0, 64, 8'h61, 1'b0, 10, 0,  5, 32'h61616161, 1'b0};
    vt[9] = '{0, 64, 8'h61, 1'b0, 10, 1, 14, 32'h00000200, 1'b1};

    rst_i        = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    end_i        = 1'b0;
    blk_ready_i  = 1'b0;
    #1;
    acc = '0;
    for (int w = 0; w < 16; w++) acc |= M_o[w];
    chk("rst_m", 64'(acc), 64'd0);
    chk("rst_valid", 64'(blk_valid_o), 64'd0);
    chk("rst_last", 64'(blk_last_o), 64'd0);
    chk("rst_ready", 64'(byte_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      m = {};
      if (vt[i].kind == 1) m = {8'h61, 8'h62, 8'h63};
      else for (int j = 0; j < vt[i].len; j++) m.push_back(vt[i].fill);
      run_msg(m, vt[i].end_sep, vt[i].bp);
      chk($sformatf("vec%0d_word", i), 64'(got_w[vt[i].blk][vt[i].word]), 64'(vt[i].exp_w));
      chk($sformatf("vec%0d_last", i), 64'(got_last[vt[i].blk]), 64'(vt[i].exp_last));
    end

    // Reset while a full block is being held by backpressure.
    @(posedge clk); #1;
    for (int j = 0; j < 64; j++) xfer(8'h55, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 64'(blk_valid_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(blk_valid_o), 64'd0);
    chk("mid_rst_m0", 64'(M_o[0]), 64'd0);
    chk("mid_rst_ready", 64'(byte_ready_o), 64'd1);
    @(negedge clk);
    rst_i = 1'b1;

    // Reset after a partial message, then "abc" must look exactly like a fresh run.
    @(posedge clk); #1;
    for (int j = 0; j < 20; j++) xfer(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("part_rst_valid", 64'(blk_valid_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b1;
    run_msg({8'h61, 8'h62, 8'h63}, 1'b0, 0);
    chk("post_rst_abc_w0", 64'(got_w[0][0]), 64'h80636261);
    chk("post_rst_abc_w14", 64'(got_w[0][14]), 64'h18);

    rand_gap = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int len;
      bit es;
      m   = {};
      len = $urandom_range(0, 140);
      for (int j = 0; j < len; j++) m.push_back(8'($urandom_range(0, 255)));
      es = ($urandom_range(0, 1) == 1);
      run_msg(m, es, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
